alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
Issue stage that sits directly upstream of the combinational 16-bit ALU. It accepts one operation at a time over a valid/ready handshake, drives the ALU's operand and opcode inputs from registers, and captures the ALU result. The ALU has no multiplier, so this block executes opcode 3'b001 (MULTIPLY) itself with an iterative shift-add unit. It returns every result over a valid/ready output handshake.

Parameters:
DATA_W, 16, operand/result width; must match ALU width (only 16 is supported).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream operation valid
in_ready  output  1  block can accept an operation
in_opcode  input  3  000 ADD, 001 MUL, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT, 111 illegal
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
alu_a  output  DATA_W  to ALU inputA
alu_b  output  DATA_W  to ALU inputB
alu_op  output  3  to ALU opcode
alu_result  input  DATA_W  from ALU result (combinational)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  DATA_W  operation result
out_opcode  output  3  opcode of returned result
out_err  output  1  result came from illegal opcode

Behaviour:
- Reset: on a rising edge with rst=1, state goes to IDLE. alu_a, alu_b, alu_op, out_result, out_opcode and out_err all go to 0, and out_valid goes to 0. Any in-flight operation is discarded and never reported. in_valid is ignored while rst=1.
- rst has priority over every other event on the same edge.
- in_ready is 1 only in IDLE. It is decoded from state, so it is 1 in the first cycle after reset is released.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: on an edge with in_valid=1, latch in_a, in_b and in_opcode. Accept edge = E0.
  - Opcode 001: go to MUL.
  - Any other opcode: go to EXEC.
- alu_a and alu_b always show the latched operands.
- alu_op shows the latched opcode, except for opcode 111, where it is held at 000. alu_op must never present 111, which is outside the ALU's legal opcode set.
- EXEC: lasts exactly one cycle.
  - At edge E0+1, register alu_result into out_result, set out_opcode, and go to DONE.
  - For opcode 111, out_result = 0 and out_err = 1 instead.
  - Latency: out_valid is first high in the cycle after E0+1.
- MUL: computes the low 16 bits of a*b over 16 iterations, at edges E0+1 through E0+16.
  - Internal registers: acc (cleared at accept), mcand = a, mplier = b, and a 4-bit counter.
  - Each iteration: if mplier[0], acc = acc + mcand (mod 2^16); then mcand <<= 1, mplier >>= 1, count++.
  - At edge E0+16 (count == 15 before the update), load out_result with the final acc and go to DONE.
  - out_result ignores alu_result during MUL.
- DONE: out_valid = 1, with out_result, out_opcode and out_err held stable.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - A new operation can be accepted no earlier than the edge after the out handshake.
  - Throughput: one op per 3 cycles (non-MUL) or 18 cycles (MUL) with out_ready tied high.
- Arithmetic: all results are truncated mod 2^16. No carry or overflow outputs.
- out_err = 0 for every legal opcode.

Test Plan:
- ADD a=0xFFFF, b=0x0001, out_ready=1 -> alu_op=000 from the cycle after E0; out_valid in the cycle after E0+1; out_result=0x0000, out_opcode=000, out_err=0.
- SUB a=0x0000, b=0x0001 -> 0xFFFF. NOT a=0x00F0 -> 0xFF0F. XOR 0xAAAA^0x0F0F -> 0xA5A5. Each result arrives in the cycle after E0+1.
- MUL a=0x0123, b=0x0045 -> out_valid exactly in the cycle after E0+16 with out_result=0x4E6F. MUL a=0xFFFF, b=0xFFFF -> 0x0001. MUL a=0x1234, b=0 -> 0x0000.
- Backpressure: complete an AND, then hold out_ready=0 for 5 cycles -> out_valid stays 1, out_result stays stable, in_ready stays 0, and in_valid pulses are not accepted. Raise out_ready -> in_ready=1 in the next cycle.
- Illegal opcode 111 with a=0x1111, b=0x2222 -> accepted; alu_op never equals 111; out_result=0x0000, out_err=1, out_opcode=111.
- Assert rst for one cycle at the 8th MUL iteration -> all outputs 0 and in_ready=1 after release, with no out_valid for the aborted op. A following OR 0x00FF|0xFF00 -> 0xFFFF with normal latency.

Source files
------------

// File: rtl/alu_dispatch_if.sv
// Handshake and ALU-side bus of the ALU issue stage.
// The slave modport is the issue stage; the master modport is its
// environment (upstream source, ALU and downstream sink).
interface alu_dispatch_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [2:0]        out_opcode;
  logic              out_err;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_opcode, out_err
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_opcode, out_err
  );
endinterface

// File: rtl/alu_dispatch.sv
// Issue stage in front of the combinational 16-bit ALU. Accepts one
// operation at a time, drives the ALU from registered operands, runs
// MULTIPLY itself with a 16-step shift-add unit, and returns each
// result over a valid/ready handshake.
module alu_dispatch #(
  parameter int DATA_W = 16
) (
  input logic           clk,
  input logic           rst,
  alu_dispatch_if.slave bus
);

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] res;
  logic [2:0]        res_op;
  logic              res_err;

  // State register; reset returns to IDLE and drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode for accept, single-cycle execute, multiply loop and result hold.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = (bus.in_opcode == OP_MUL) ? MUL : EXEC;
      EXEC: state_nxt = DONE;
      MUL:  if (cnt == 4'd15) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
  end

  // Operand latch, multiply iteration and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      res     <= '0;
      res_op  <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a    <= bus.in_a;
            op_b    <= bus.in_b;
            op_code <= bus.in_opcode;
            acc     <= '0;
            mcand   <= bus.in_a;
            mplier  <= bus.in_b;
            cnt     <= '0;
          end
        end
        EXEC: begin
          res     <= (op_code == OP_ILL) ? '0 : bus.alu_result;
          res_op  <= op_code;
          res_err <= (op_code == OP_ILL);
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            res     <= acc_nxt;
            res_op  <= op_code;
            res_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The illegal opcode is never forwarded; the ALU sees ADD for it and its result is discarded.
  assign bus.alu_a      = op_a;
  assign bus.alu_b      = op_b;
  assign bus.alu_op     = (op_code == OP_ILL) ? 3'b000 : op_code;
  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = res;
  assign bus.out_opcode = res_op;
  assign bus.out_err    = res_err;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural model of the ALU.
module tb_alu_dispatch;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic bad_op   = 1'b0;

  always #5 clk = ~clk;

  alu_dispatch_if #(.DATA_W(16)) bus ();

  alu_dispatch #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Combinational ALU model (no multiplier)
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b100:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b101:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b110:  bus.alu_result = ~bus.alu_a;
      default: bus.alu_result = 16'h0000;
    endcase
  end

  // Watch for the illegal opcode ever reaching the ALU
  always @(negedge clk) begin
    if (bus.alu_op == 3'b111) bad_op = 1'b1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic exp_err, input int lat, input bit hs);
    logic [2:0] exp_alu_op;
    exp_alu_op = (op == 3'b111) ? 3'b000 : op;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    step();
    bus.in_valid  = 1'b0;
    chk({tag, "_alu_op"}, 16'(bus.alu_op), 16'(exp_alu_op));
    chk({tag, "_alu_a"}, bus.alu_a, a);
    chk({tag, "_alu_b"}, bus.alu_b, b);
    repeat (lat - 1) step();
    chk({tag, "_valid_early"}, 16'(bus.out_valid), 16'd0);
    step();
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_result"}, bus.out_result, exp_res);
    chk({tag, "_opcode"}, 16'(bus.out_opcode), 16'(op));
    chk({tag, "_err"}, 16'(bus.out_err), 16'(exp_err));
    chk({tag, "_busy"}, 16'(bus.in_ready), 16'd0);
    if (hs) begin
      bus.out_ready = 1'b1;
      step();
      chk({tag, "_ready_after"}, 16'(bus.in_ready), 16'd1);
      chk({tag, "_valid_after"}, 16'(bus.out_valid), 16'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 3'b000;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_alu_a", bus.alu_a, 16'h0000);
    chk("rst_alu_op", 16'(bus.alu_op), 16'd0);
    chk("rst_out_result", bus.out_result, 16'h0000);
    chk("rst_out_err", 16'(bus.out_err), 16'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);

    run_op("add", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1, 1'b1);
    run_op("sub", 3'b010, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1, 1'b1);
    run_op("not", 3'b110, 16'h00F0, 16'h0000, 16'hFF0F, 1'b0, 1, 1'b1);
    run_op("xor", 3'b101, 16'hAAAA, 16'h0F0F, 16'hA5A5, 1'b0, 1, 1'b1);
    run_op("mul1", 3'b001, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 16, 1'b1);
    run_op("mul2", 3'b001, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 16, 1'b1);
    run_op("mul3", 3'b001, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16, 1'b1);

    // Backpressure: result must be held while new requests are refused
    bus.out_ready = 1'b0;
    run_op("and", 3'b011, 16'h3C3C, 16'h0FF0, 16'h0C30, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_opcode = 3'b000;
      bus.in_a      = 16'hDEAD;
      bus.in_b      = 16'hBEEF;
      step();
      chk("bp_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_result", bus.out_result, 16'h0C30);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_ready", 16'(bus.in_ready), 16'd1);
    chk("bp_not_accepted", bus.alu_a, 16'h3C3C);
    step();
    chk("bp_idle_ready", 16'(bus.in_ready), 16'd1);

    run_op("ill", 3'b111, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1, 1'b1);

    // Reset in the 8th multiply iteration discards the operation
    bus.in_valid  = 1'b1;
    bus.in_opcode = 3'b001;
    bus.in_a      = 16'h0123;
    bus.in_b      = 16'h0045;
    step();
    bus.in_valid  = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 16'(bus.in_ready), 16'd1);
    chk("abort_alu_a", bus.alu_a, 16'h0000);
    chk("abort_alu_b", bus.alu_b, 16'h0000);
    chk("abort_alu_op", 16'(bus.alu_op), 16'd0);
    chk("abort_out_result", bus.out_result, 16'h0000);
    chk("abort_out_opcode", 16'(bus.out_opcode), 16'd0);
    chk("abort_out_err", 16'(bus.out_err), 16'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_valid", 16'(bus.out_valid), 16'd0);
      step();
    end
    run_op("or", 3'b100, 16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 1, 1'b1);

    chk("alu_op_never_111", 16'(bad_op), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
